// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared single-port RAM between fetch and data-memory requesters.
// Optional `ARB_STARVE_GUARD_EN` bounds data-grant runs so a waiting fetch is served.
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int RD_LAT     = 2,
  parameter int MAX_DM_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [31:0]       dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              stall_fetch,
  output logic              stall_mem
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  if (RD_LAT < 1 || MAX_DM_RUN < 1 || MAX_DM_RUN > 7) begin : g_bad_params
    $error("mem_port_arbiter: RD_LAT must be >= 1 and MAX_DM_RUN within 1..7");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_owner_dm;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mem_en;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic               r_if_rvalid;
  logic               r_dm_rvalid;
  logic [31:0]        r_if_rdata;
  logic [31:0]        r_dm_rdata;
  logic               w_force_if;

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] r_dm_run;

  // Counts data grants taken while fetch is waiting; any fetch grant or idle fetch resets it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dm_run <= '0;
    end else if (if_gnt || !if_req) begin
      r_dm_run <= '0;
    end else if (dm_gnt) begin
      r_dm_run <= r_dm_run + 3'd1;
    end
  end

  assign w_force_if = if_req && (r_dm_run == 3'(MAX_DM_RUN));
`else
  assign w_force_if = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (if_gnt || dm_gnt) w_next = S_ISSUE;
      S_ISSUE: w_next = r_mem_we ? S_IDLE : S_WAIT;
      S_WAIT:  if (r_cnt == CNT_W'(1)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (r_state == S_IDLE) begin
      if (if_req && (!dm_req || w_force_if)) begin
        if_gnt = 1'b1;
      end else if (dm_req) begin
        dm_gnt = 1'b1;
      end
    end
  end

  // RAM command registers double as the latched transaction; mem_en/mem_we last only the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner_dm  <= 1'b0;
      r_cnt       <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (if_gnt || dm_gnt) begin
            r_owner_dm <= dm_gnt;
            r_mem_en   <= 1'b1;
            r_mem_we   <= dm_gnt && dm_we;
            r_mem_addr <= dm_gnt ? dm_addr : if_addr;
            if (dm_gnt) r_mem_wdata <= dm_wdata;
          end
        end
        S_ISSUE: r_cnt <= CNT_W'(RD_LAT);
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            if (r_owner_dm) begin
              r_dm_rdata  <= mem_rdata;
              r_dm_rvalid <= 1'b1;
            end else begin
              r_if_rdata  <= mem_rdata;
              r_if_rvalid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign if_rvalid   = r_if_rvalid;
  assign dm_rvalid   = r_dm_rvalid;
  assign if_rdata    = r_if_rdata;
  assign dm_rdata    = r_dm_rdata;
  assign stall_fetch = if_req && !if_gnt;
  assign stall_mem   = dm_req && !dm_gnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural RAM of latency RD_LAT.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 8;
  localparam int RD_LAT     = 2;
  localparam int MAX_DM_RUN = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [31:0]       dm_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              stall_fetch;
  logic              stall_mem;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .MAX_DM_RUN(MAX_DM_RUN)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_fetch(stall_fetch), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: data for a read issued in cycle C is presented during cycle C+RD_LAT.
  logic [31:0]       ram [0:255];
  logic              p_v    [RD_LAT];
  logic [ADDR_W-1:0] p_addr [RD_LAT];

  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    p_v[0]    <= mem_en && !mem_we;
    p_addr[0] <= mem_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      p_v[i]    <= p_v[i-1];
      p_addr[i] <= p_addr[i-1];
    end
  end

  assign mem_rdata = p_v[RD_LAT-1] ? ram[p_addr[RD_LAT-1]] : 32'hBADBAD00;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_if [$];
  logic [31:0] exp_dm [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (if_rvalid) begin
      if (exp_if.size() == 0) begin
        checks++; errors++;
        $display("FAIL if_rvalid_unexpected actual=1 expected=0 data=%0h (cycle %0d)", if_rdata, cyc);
      end else begin
        check("if_rdata", 128'(if_rdata), 128'(exp_if.pop_front()));
      end
    end
    if (dm_rvalid) begin
      if (exp_dm.size() == 0) begin
        checks++; errors++;
        $display("FAIL dm_rvalid_unexpected actual=1 expected=0 data=%0h (cycle %0d)", dm_rdata, cyc);
      end else begin
        check("dm_rdata", 128'(dm_rdata), 128'(exp_dm.pop_front()));
      end
    end
  end

  task automatic wait_gnt(input bit is_dm, output int gc);
    gc = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (is_dm ? dm_gnt : if_gnt) begin
        gc = cyc;
        break;
      end
    end
    if (gc < 0) begin
      checks++; errors++;
      $display("FAIL %s_gnt_timeout actual=none expected=grant", is_dm ? "dm" : "if");
    end
  endtask

  task automatic wait_rv(input bit is_dm, output int rc);
    rc = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (is_dm ? dm_rvalid : if_rvalid) begin
        rc = cyc;
        break;
      end
    end
    if (rc < 0) begin
      checks++; errors++;
      $display("FAIL %s_rvalid_timeout actual=none expected=pulse", is_dm ? "dm" : "if");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, g1, g2, gi, rc, n, saw;
    logic [9:0] seq;
    logic [9:0] seq_exp;

    for (int i = 0; i < 256; i++) ram[i] = '0;
    ram[8'h10] = 32'hE3A01005;
    ram[8'h30] = 32'h12345678;
    ram[8'h40] = 32'hCAFEF00D;
    for (int i = 0; i < RD_LAT; i++) begin p_v[i] = 1'b0; p_addr[i] = '0; end

    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          128'({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we, stall_fetch, stall_mem,
                mem_addr, mem_wdata, if_rdata, dm_rdata}), '0);
    @(posedge clk); #1 rst = 1'b0;

    // Lone fetch
    @(posedge clk); #1 if_addr = 8'h10; if_req = 1'b1;
    wait_gnt(1'b0, t);
    @(posedge clk); #1 if_req = 1'b0;
    exp_if.push_back(32'hE3A01005);
    @(negedge clk);
    check("fetch_issue", 128'({mem_en, mem_we, mem_addr}), 128'({1'b1, 1'b0, 8'h10}));
    wait_rv(1'b0, rc);
    check("fetch_latency", 128'(rc - t), 128'(2 + RD_LAT));

    // Store then load of the same word
    @(posedge clk); #1 dm_addr = 8'h20; dm_we = 1'b1; dm_wdata = 32'hDEADBEEF; dm_req = 1'b1;
    wait_gnt(1'b1, g1);
    @(posedge clk); #1 dm_we = 1'b0;
    wait_gnt(1'b1, g2);
    @(posedge clk); #1 dm_req = 1'b0;
    exp_dm.push_back(32'hDEADBEEF);
    check("store_to_load_gap", 128'(g2 - g1), 128'(2));
    wait_rv(1'b1, rc);
    check("load_latency", 128'(rc - g2), 128'(2 + RD_LAT));

    // Simultaneous requests: data first, fetch granted alongside the data rvalid
    @(posedge clk); #1
    if_addr = 8'h30; if_req = 1'b1; dm_addr = 8'h40; dm_we = 1'b0; dm_req = 1'b1;
    @(negedge clk);
    t = cyc;
    check("simul_first_grant", 128'({dm_gnt, if_gnt, stall_fetch, stall_mem}), 128'(4'b1010));
    @(posedge clk); #1 dm_req = 1'b0;
    exp_dm.push_back(32'hCAFEF00D);
    wait_gnt(1'b0, gi);
    check("simul_fetch_gnt_cycle", 128'(gi - t), 128'(2 + RD_LAT));
    check("simul_dm_rvalid_with_if_gnt", 128'(dm_rvalid), 128'(1));
    @(posedge clk); #1 if_req = 1'b0;
    exp_if.push_back(32'h12345678);
    wait_rv(1'b0, rc);

    // Continuous stores with a waiting fetch
    @(posedge clk); #1
    if_addr = 8'h10; if_req = 1'b1;
    dm_addr = 8'h60; dm_we = 1'b1; dm_wdata = 32'h0000_0A5A; dm_req = 1'b1;
    seq = '0; n = 0;
    for (int k = 0; k < 120 && n < 10; k++) begin
      @(negedge clk);
      if (dm_gnt) n++;
      if (if_gnt) begin
        seq[n] = 1'b1;
        n++;
        exp_if.push_back(32'hE3A01005);
      end
    end
    @(posedge clk); #1 if_req = 1'b0; dm_req = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    seq_exp = 10'b10_0001_0000;
`else
    seq_exp = 10'b00_0000_0000;
`endif
    check("grant_sequence", 128'({4'(n), seq}), 128'({4'd10, seq_exp}));
    repeat (10) @(posedge clk);

    // Reset during the WAIT phase of a fetch
    #1 if_addr = 8'h10; if_req = 1'b1;
    wait_gnt(1'b0, t);
    @(posedge clk); #1 if_req = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_outputs",
          128'({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we, stall_fetch, stall_mem,
                mem_addr, mem_wdata, if_rdata, dm_rdata}), '0);
    @(posedge clk); #1 dm_addr = 8'h70; dm_we = 1'b1; dm_wdata = 32'h1; dm_req = 1'b1;
    @(negedge clk);
    check("post_reset_dm_gnt", 128'({dm_gnt, if_gnt}), 128'(2'b10));
    @(posedge clk); #1 dm_req = 1'b0;
    saw = 0;
    repeat (8) begin
      @(negedge clk);
      if (if_rvalid) saw++;
    end
    check("post_reset_no_if_rvalid", 128'(saw), '0);

    check("scoreboard_drained", 128'(exp_if.size() + exp_dm.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
